// File: rtl/wk_fetch_pkg.sv
// Shared types and constants for the weight-memory read initiator.
// Holds the fetch FSM state encoding and the default weight matrix size.
package wk_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam int WEIGHT_WORDS = 2048;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous return buffer, WIDTH x DEPTH, same-cycle push and pop.
// Ports: clk, rst, push/din, pop/dout (head), count, empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             full;

  assign dout  = mem[rp];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Issue throttling upstream must make overflow impossible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/wk_fetch.sv
// Weight memory read initiator: walks a word range, buffers returns, streams.
// Ports: start/base_addr/num_words cmd, busy/done, mem_* read port, w_* stream.
module wk_fetch
  import wk_fetch_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              mem_write_en,
  output logic [WIDTH-1:0]  mem_data_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_data_out,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WIDTH-1:0]  w_data,
  output logic              w_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 2;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  num_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  popped;
  // rq: address on the bus this cycle; inflight: its data on mem_data_out
  logic              rq;
  logic              inflight;

  logic [AW:0]       count;
  logic              empty;
  logic [WIDTH-1:0]  head;
  logic              pop;
  logic              start_ok;
  logic              rd_issue;
  logic              last_pop;
  logic [OW-1:0]     occ;

  assign mem_write_en = 1'b0;
  assign mem_data_in  = '0;

  assign pop      = !empty && w_ready;
  assign start_ok = (state == IDLE) && start;

  // Words buffered or still on their way back, with a same-cycle pop freed.
  assign occ = OW'(count) + OW'(rq) + OW'(inflight) - OW'(pop);

  // The first read goes out with the accepted start.
  assign rd_issue = (start_ok && num_words != '0) ||
                    (state == FETCH && occ < OW'(FIFO_DEPTH));

  assign w_valid  = !empty;
  assign w_data   = empty ? '0 : head;
  assign w_last   = w_valid && (popped == num_q - LEN_W'(1));
  assign last_pop = pop && w_last;

  assign busy = (state == FETCH) || (state == DRAIN);
  assign done = (state == DONE);

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   (mem_data_out),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= '0;
      num_q    <= '0;
      issued   <= '0;
      popped   <= '0;
      rq       <= 1'b0;
      inflight <= 1'b0;
      mem_addr <= '0;
    end else begin
      rq       <= rd_issue;
      inflight <= rq;
      if (pop) popped <= popped + 1'b1;
      if (rd_issue) begin
        mem_addr <= start_ok ? base_addr
                             : base_q + ADDR_W'(issued);
        issued   <= start_ok ? LEN_W'(1) : issued + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            num_q  <= num_words;
            popped <= '0;
            if (num_words == '0)
              state <= DONE;
            else if (num_words == LEN_W'(1))
              state <= DRAIN;
            else
              state <= FETCH;
          end
        end
        FETCH: begin
          if (rd_issue && issued == num_q - LEN_W'(1))
            state <= DRAIN;
        end
        DRAIN: begin
          if (last_pop) state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wk_fetch.sv
// Directed bench for wk_fetch with an address-echo memory model.
// Word at address a reads back as a; stream is checked word by word.
module tb_wk_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_words;
  logic        busy;
  logic        done;
  logic        mem_write_en;
  logic [63:0] mem_data_in;
  logic [31:0] mem_addr;
  logic [63:0] mem_data_out;
  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic        w_last;

  int n_tests = 0;
  int n_fail  = 0;

  wk_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .mem_write_en (mem_write_en),
    .mem_data_in  (mem_data_in),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .w_last       (w_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data_out <= {32'h0, mem_addr};

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // evt: 0 none, 1 restart attempt at word evt_k, 2 reset at word evt_k
  task automatic xfer(input logic [31:0] base,
                      input logic [15:0] num,
                      input bit          rnd,
                      input int          evt_k,
                      input int          evt);
    int          c;
    int          k;
    int          budget;
    bit          stalled;
    bit          inj;
    bit          r;
    logic [63:0] prev;
    logic [31:0] a;
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    num_words = num;
    w_ready   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = ~base;
    num_words = num + 16'd3;
    c       = 0;
    k       = 0;
    stalled = 1'b0;
    inj     = 1'b0;
    prev    = '0;
    budget  = 4 * int'(num) + 32;
    while (c < budget) begin
      if (start) start = 1'b0;
      if (k == int'(num)) begin
        check("done", 64'(done), 64'd1);
        check("busy_end", 64'(busy), 64'd0);
        check("wvalid_end", 64'(w_valid), 64'd0);
        break;
      end
      if (c == 0) check("busy_on", 64'(busy), 64'd1);
      if (rnd) check("mem_we", 64'(mem_write_en), 64'd0);
      if (!rnd && c < int'(num)) begin
        a = base + 32'(c);
        check("mem_addr", 64'(mem_addr), 64'(a));
      end
      if (stalled) begin
        check("hold_valid", 64'(w_valid), 64'd1);
        check("hold_data", w_data, prev);
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready = r;
      if (w_valid && r) begin
        a = base + 32'(k);
        if (!rnd && k == 0) check("latency", 64'(c), 64'd2);
        check("data", w_data, {32'h0, a});
        check("last", 64'(w_last), 64'(k == int'(num) - 1));
        k++;
      end
      stalled = w_valid && !r;
      prev    = w_data;
      if (evt == 1 && k == evt_k && !inj) begin
        start     = 1'b1;
        base_addr = 32'h9000;
        num_words = 16'd5;
        inj       = 1'b1;
      end
      if (evt == 2 && k == evt_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(w_valid), 64'd0);
        check("rst_last", 64'(w_last), 64'd0);
        check("rst_data", w_data, 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        repeat (4) begin
          @(negedge clk);
          check("no_done", 64'(done), 64'd0);
        end
        return;
      end
      @(negedge clk);
      c++;
    end
    check("complete", 64'(k), 64'(num));
    w_ready = 1'b1;
  endtask

  logic [31:0] addr_hold;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    w_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_valid", 64'(w_valid), 64'd0);
    check("reset_last", 64'(w_last), 64'd0);
    check("reset_data", w_data, 64'd0);
    check("reset_addr", 64'(mem_addr), 64'd0);
    check("reset_we", 64'(mem_write_en), 64'd0);
    check("reset_wdata", mem_data_in, 64'd0);
    rst = 1'b0;

    xfer(32'h0, 16'd2048, 1'b0, 0, 0);
    xfer(32'h0, 16'd2048, 1'b1, 0, 0);

    @(negedge clk);
    addr_hold = mem_addr;
    start     = 1'b1;
    base_addr = 32'h1234;
    num_words = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_valid", 64'(w_valid), 64'd0);
    check("zero_addr", 64'(mem_addr), 64'(addr_hold));
    @(negedge clk);
    check("zero_done_off", 64'(done), 64'd0);
    check("zero_busy_off", 64'(busy), 64'd0);

    xfer(32'h100, 16'd64, 1'b0, 10, 1);
    xfer(32'h0, 16'd2048, 1'b0, 100, 2);
    xfer(32'd2048, 16'd16, 1'b0, 0, 0);
    xfer(32'hFFFF_FFFE, 16'd4, 1'b0, 0, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
